// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential shift-add multiply-accumulate unit.
//   state_t            : controller states (IDLE, RUN, DONE)
//   MUL_WIDTH_DEFAULT  : default operand width
//   MUL_CNT_W          : iteration counter width for the default operand width
//   mul_cnt_width()    : iteration counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int MUL_WIDTH_DEFAULT = 16;

   // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
   function automatic int mul_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int MUL_CNT_W = $clog2(MUL_WIDTH_DEFAULT + 1);

endpackage : mul_pkg

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Sequential shift-add multiply-accumulate:
//   product = multiplicand * multiplier + addend   (unsigned, 2*WIDTH-bit result)
// One multiplier bit is consumed per clock under a start/done handshake. Also
// used to rebuild dividend = quotient * divisor + remainder for the divide path.
//
// Optional feature (compile-time macro MUL_EARLY_EXIT_EN):
//   defined   : RUN also ends as soon as the remaining multiplier bits are all
//               zero (minimum one RUN cycle); results are unchanged.
//   undefined : latency is always WIDTH cycles, independent of the data.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   request, sampled only while ready=1
//   multiplicand  in   [WIDTH-1:0]   operand A, captured on accept
//   multiplier    in   [WIDTH-1:0]   operand B, captured on accept
//   addend        in   [WIDTH-1:0]   operand C, captured on accept
//   ready         out  high in IDLE only
//   busy          out  high in RUN and DONE
//   done          out  one-cycle pulse marking a new product
//   product       out  [2*WIDTH-1:0] result, held until the next done
//   overflow      out  upper half of product is non-zero
// -----------------------------------------------------------------------------
module seq_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     addend,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic                 overflow
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = mul_cnt_width(WIDTH);

   state_t           state;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] count;

   // Datapath for the current RUN iteration. The sum cannot wrap: the largest
   // possible result is 2^(2W) - 2^W.
   logic [PW-1:0]    acc_next;
   logic [WIDTH-1:0] mplier_next;
   logic [CNT_W-1:0] count_next;
   logic             last_iter;

   assign acc_next    = mplier[0] ? (acc + mcand) : acc;
   assign mplier_next = mplier >> 1;
   assign count_next  = count - CNT_W'(1);

`ifdef MUL_EARLY_EXIT_EN
   // Once every remaining multiplier bit is zero, further iterations add
   // nothing, so the accumulator already holds the final result.
   assign last_iter = (count_next == '0) || (mplier_next == '0);
`else
   assign last_iter = (count_next == '0);
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, regardless of statement order.
   // NOTE: the working registers are reset too, so an aborted operation leaves
   // no stale operand data behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         count    <= '0;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         product  <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  acc    <= PW'(addend);
                  mcand  <= PW'(multiplicand);
                  mplier <= multiplier;
                  count  <= CNT_W'(WIDTH);
                  state  <= S_RUN;
                  ready  <= 1'b0;
                  busy   <= 1'b1;
               end
            end

            S_RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier_next;
               count  <= count_next;
               if (last_iter) begin
                  product  <= acc_next;
                  overflow <= |acc_next[PW-1:WIDTH];
                  done     <= 1'b1;
                  state    <= S_DONE;
               end
            end

            S_DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule : seq_multiplier

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential shift-add multiply-accumulate unit computing product = multiplicand × multiplier + addend on unsigned WIDTH-bit operands, with a full 2·WIDTH-bit result. It is the inverse of the CPU's divide path. It rebuilds dividend = quotient × divisor + remainder, and serves as the CPU's MUL execution resource. Operation is one partial-product bit per clock under a start/done handshake.

## Interface
- WIDTH, 16, operand width in bits; product is 2·WIDTH bits
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- multiplicand  input  WIDTH  unsigned operand A, captured when start is accepted
- multiplier  input  WIDTH  unsigned operand B, captured when start is accepted
- addend  input  WIDTH  unsigned value added to A×B, captured when start is accepted
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN and DONE
- done  output  1  single-cycle pulse marking a valid new product
- product  output  2·WIDTH  result register; holds its value until the next done
- overflow  output  1  product[2·WIDTH-1:WIDTH] ≠ 0; updated together with product

## Operation
- States:
  - IDLE: ready=1.
  - RUN: iterate.
  - DONE: done=1 for one cycle, then return to IDLE.
- IDLE, with start=1 at an edge:
  - Load acc = zero-extended addend.
  - Load mcand = zero-extended multiplicand (2·WIDTH bits).
  - Load mplier = multiplier.
  - Set count = WIDTH.
  - Go to RUN.
- RUN, each edge:
  - If mplier[0], acc += mcand (2·WIDTH-bit add).
  - mcand <<= 1; mplier >>= 1; count -= 1.
  - When count reaches 0, load product and overflow from the final acc and go to DONE.
- DONE: next edge → IDLE, unconditionally.
- start outside IDLE is ignored. It is not queued and does not disturb the operation in flight.
- Arithmetic cannot wrap: max result = (2^W−1)² + (2^W−1) = 2^(2W) − 2^W < 2^(2W).
- Operands are sampled only at the accepting edge. Input changes afterwards have no effect.
- Reset (at any time, including mid-RUN):
  - state=IDLE, product=0, overflow=0, done=0, ready=1, busy=0.
  - Internal registers are cleared.
  - An aborted operation produces no done.

## Timing
- Edge 0: start accepted. Edges 1..WIDTH: iterations. done is high in the cycle after edge WIDTH.
- Latency from the accepting edge to done visible is WIDTH cycles. For WIDTH=16 this is 16 cycles.
- ready reasserts the cycle after done. A new start can be accepted WIDTH+2 edges after the previous one.
- product and overflow change only at the edge that raises done.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - RUN also exits to DONE at any edge where the shifted mplier becomes 0.
  - Minimum one RUN edge, so multiplier 0 or 1 gives latency 1.
  - Otherwise latency = 1 + index of the multiplier's most significant set bit.
  - Results are identical to full-length operation.
- MUL_EARLY_EXIT_EN undefined: latency is always WIDTH and independent of data.

## Structure
- Shared package mul_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - MUL_WIDTH_DEFAULT = 16;
  - the count-width constant, $clog2(WIDTH+1).
- No sub-module: the datapath is one accumulator adder plus shift registers, kept in one module.

## Test plan
All scenarios use WIDTH=16.
- Basic: A=0x0003, B=0x0005, C=0x0002 → product=0x00000011, overflow=0. done 16 cycles after start; 3 cycles with MUL_EARLY_EXIT_EN.
- Max: A=0xFFFF, B=0xFFFF, C=0xFFFF → product=0xFFFF0000, overflow=1, no wrap.
- Zero multiplier: A=0xABCD, B=0x0000, C=0x1234 → product=0x00001234, overflow=0. done after 16 cycles; 1 cycle with MUL_EARLY_EXIT_EN.
- Divide round-trip: quotient 0x0007, divisor 0x0009, remainder 0x0004 → product=0x00000043, matching the dividend.
- Busy start:
  - Start A=2, B=3, C=0.
  - Pulse start with A=0x00FF, B=0x00FF, C=0 at cycle 5.
  - Required: only one done; product=0x00000006; ready=0 during the pulse.
- Mid-op reset:
  - Start A=0x1234, B=0x8000, C=0.
  - Drop rst_n at cycle 8.
  - Required: immediately product=0, done=0, ready=1; no done follows.
  - Next op A=4, B=4, C=1 → product=0x00000011.
